// File: rtl/gate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gate_scheduler
// Purpose  : Assembles decoded gates into jobs, buffers one pending job and
//            sequences label reads, evaluation (BUF/XOR local, AND external)
//            and the output-label write.
// Revision : 1.0 - initial release
// ============================================================================
module gate_scheduler #(
  parameter int LABEL_W = 128,
  parameter int ADDR_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           gate_type,
  input  logic [23:0]          input_id,
  input  logic [127:0]         ctxt,
  input  logic [1:0]           ctxt_idx,
  input  logic [23:0]          gate_id,
  input  logic                 gate_strobe,
  input  logic                 id_1_strobe,
  input  logic                 id_2_strobe,
  input  logic                 ctxt_strobe,
  input  logic                 gate_id_strobe,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LABEL_W-1:0]   mem_wr_data,
  input  logic [LABEL_W-1:0]   mem_rd_data,
  output logic                 eval_valid,
  input  logic                 eval_ready,
  output logic [LABEL_W-1:0]   eval_a,
  output logic [LABEL_W-1:0]   eval_b,
  output logic [383:0]         eval_ctxt,
  input  logic                 eval_done,
  input  logic [LABEL_W-1:0]   eval_result,
  output logic                 busy,
  output logic                 overflow,
  output logic                 bad_job,
  output logic [31:0]          gates_done
);

  localparam logic [1:0] c_AND = 2'd0;
  localparam logic [1:0] c_XOR = 2'd1;
  localparam logic [1:0] c_BUF = 2'd2;
  localparam logic [1:0] c_ILL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_A      = 3'd1,
    S_RD_B      = 3'd2,
    S_LAT_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_EVAL_WAIT = 3'd5,
    S_WRITE     = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic r_gate_q, r_id1_q, r_id2_q, r_ctxt_q, r_gid_q;
  logic w_gate_edge, w_id1_edge, w_id2_edge, w_ctxt_edge, w_commit;

  // job under assembly
  logic [1:0]   r_asm_type;
  logic [23:0]  r_asm_id1, r_asm_id2;
  logic [383:0] r_asm_ctxt;

  // pending slot
  logic         r_p_valid;
  logic [1:0]   r_p_type;
  logic [23:0]  r_p_id1, r_p_id2, r_p_gid;
  logic [383:0] r_p_ctxt;

  // working job
  logic [1:0]         r_w_type;
  logic [23:0]        r_w_id1, r_w_id2, r_w_gid;
  logic [383:0]       r_w_ctxt;
  logic [LABEL_W-1:0] r_a, r_b, r_result;

  logic r_overflow, r_bad_job;
  logic [31:0] r_gates_done;
  logic w_take, w_bad;

  assign w_gate_edge = gate_strobe    & ~r_gate_q;
  assign w_id1_edge  = id_1_strobe    & ~r_id1_q;
  assign w_id2_edge  = id_2_strobe    & ~r_id2_q;
  assign w_ctxt_edge = ctxt_strobe    & ~r_ctxt_q;
  assign w_commit    = gate_id_strobe & ~r_gid_q;

  assign w_take = (r_state == S_IDLE) && r_p_valid;

  // id2 only matters for two-input gates
  assign w_bad = (r_asm_type == c_ILL)
              || ((gate_id   >> ADDR_W) != 24'd0)
              || ((r_asm_id1 >> ADDR_W) != 24'd0)
              || ((r_asm_type != c_BUF) && ((r_asm_id2 >> ADDR_W) != 24'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    eval_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_p_valid) w_next = S_RD_A;
      end
      S_RD_A: begin
        mem_rd_en = 1'b1;
        mem_addr  = r_w_id1[ADDR_W-1:0];
        w_next    = S_RD_B;
      end
      S_RD_B: begin
        if (r_w_type == c_BUF) begin
          w_next = S_WRITE;
        end else begin
          mem_rd_en = 1'b1;
          mem_addr  = r_w_id2[ADDR_W-1:0];
          w_next    = S_LAT_B;
        end
      end
      S_LAT_B: begin
        w_next = (r_w_type == c_XOR) ? S_WRITE : S_EXEC;
      end
      S_EXEC: begin
        eval_valid = 1'b1;
        if (eval_ready) w_next = S_EVAL_WAIT;
      end
      S_EVAL_WAIT: begin
        if (eval_done) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = r_w_gid[ADDR_W-1:0];
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_q     <= 1'b0;
      r_id1_q      <= 1'b0;
      r_id2_q      <= 1'b0;
      r_ctxt_q     <= 1'b0;
      r_gid_q      <= 1'b0;
      r_asm_type   <= '0;
      r_asm_id1    <= '0;
      r_asm_id2    <= '0;
      r_asm_ctxt   <= '0;
      r_p_valid    <= 1'b0;
      r_p_type     <= '0;
      r_p_id1      <= '0;
      r_p_id2      <= '0;
      r_p_gid      <= '0;
      r_p_ctxt     <= '0;
      r_w_type     <= '0;
      r_w_id1      <= '0;
      r_w_id2      <= '0;
      r_w_gid      <= '0;
      r_w_ctxt     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_overflow   <= 1'b0;
      r_bad_job    <= 1'b0;
      r_gates_done <= '0;
    end else begin
      r_gate_q <= gate_strobe;
      r_id1_q  <= id_1_strobe;
      r_id2_q  <= id_2_strobe;
      r_ctxt_q <= ctxt_strobe;
      r_gid_q  <= gate_id_strobe;

      if (w_gate_edge) r_asm_type <= gate_type;
      if (w_id1_edge)  r_asm_id1  <= input_id;
      if (w_id2_edge)  r_asm_id2  <= input_id;
      if (w_ctxt_edge) begin
        case (ctxt_idx)
          2'd1:    r_asm_ctxt[127:0]   <= ctxt;
          2'd2:    r_asm_ctxt[255:128] <= ctxt;
          2'd3:    r_asm_ctxt[383:256] <= ctxt;
          default: ;
        endcase
      end

      if (w_take) begin
        r_p_valid <= 1'b0;
        r_w_type  <= r_p_type;
        r_w_id1   <= r_p_id1;
        r_w_id2   <= r_p_id2;
        r_w_gid   <= r_p_gid;
        r_w_ctxt  <= r_p_ctxt;
      end

      // a commit in the same cycle as a take refills the freed slot
      if (w_commit) begin
        if (w_bad) begin
          r_bad_job <= 1'b1;
        end else if (r_p_valid && !w_take) begin
          r_overflow <= 1'b1;
        end else begin
          r_p_valid <= 1'b1;
          r_p_type  <= r_asm_type;
          r_p_id1   <= r_asm_id1;
          r_p_id2   <= r_asm_id2;
          r_p_gid   <= gate_id;
          r_p_ctxt  <= r_asm_ctxt;
        end
      end

      case (r_state)
        S_RD_B: begin
          r_a <= mem_rd_data;
          if (r_w_type == c_BUF) r_result <= mem_rd_data;
        end
        S_LAT_B: begin
          r_b <= mem_rd_data;
          if (r_w_type == c_XOR) r_result <= r_a ^ mem_rd_data;
        end
        S_EVAL_WAIT: begin
          if (eval_done) r_result <= eval_result;
        end
        S_WRITE: begin
          r_gates_done <= r_gates_done + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_wr_data = r_result;
  assign eval_a      = r_a;
  assign eval_b      = r_b;
  assign eval_ctxt   = r_w_ctxt;
  assign busy        = (r_state != S_IDLE) || r_p_valid;
  assign overflow    = r_overflow;
  assign bad_job     = r_bad_job;
  assign gates_done  = r_gates_done;

  logic w_unused;
  assign w_unused = ^{r_b, c_AND};

endmodule
`default_nettype wire

// File: tb/tb_gate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_scheduler
// Purpose  : Directed self-checking bench for gate_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_scheduler;

  localparam int c_LW = 128;
  localparam int c_AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]   gate_type = '0;
  logic [23:0]  input_id = '0;
  logic [127:0] ctxt = '0;
  logic [1:0]   ctxt_idx = '0;
  logic [23:0]  gate_id = '0;
  logic gate_strobe = 0, id_1_strobe = 0, id_2_strobe = 0, ctxt_strobe = 0, gate_id_strobe = 0;
  logic mem_rd_en, mem_wr_en;
  logic [c_AW-1:0] mem_addr;
  logic [c_LW-1:0] mem_wr_data;
  logic [c_LW-1:0] mem_rd_data;
  logic eval_valid;
  logic eval_ready = 1'b0;
  logic [c_LW-1:0] eval_a, eval_b;
  logic [383:0] eval_ctxt;
  logic eval_done = 1'b0;
  logic [c_LW-1:0] eval_result = '0;
  logic busy, overflow, bad_job;
  logic [31:0] gates_done;

  gate_scheduler #(.LABEL_W(c_LW), .ADDR_W(c_AW)) dut (
    .clk(clk), .rst(rst), .gate_type(gate_type), .input_id(input_id), .ctxt(ctxt),
    .ctxt_idx(ctxt_idx), .gate_id(gate_id), .gate_strobe(gate_strobe),
    .id_1_strobe(id_1_strobe), .id_2_strobe(id_2_strobe), .ctxt_strobe(ctxt_strobe),
    .gate_id_strobe(gate_id_strobe), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_a(eval_a), .eval_b(eval_b),
    .eval_ctxt(eval_ctxt), .eval_done(eval_done), .eval_result(eval_result),
    .busy(busy), .overflow(overflow), .bad_job(bad_job), .gates_done(gates_done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] c_L1 = 128'h1111_0000_aaaa_5555_1234_5678_9abc_def0;
  localparam logic [127:0] c_L2 = 128'h2222_ffff_0f0f_f0f0_8765_4321_0fed_cba9;
  localparam logic [127:0] c_L5 = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
  localparam logic [127:0] c_L6 = 128'h0bad_c0de_7654_3210_fedc_ba98_1357_9bdf;
  localparam logic [127:0] c_L7 = 128'h7777_1234_4321_abcd_dcba_5a5a_a5a5_0707;
  localparam logic [127:0] c_C0 = 128'hc0c0_c0c0_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] c_C1 = 128'hc1c1_c1c1_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] c_C2 = 128'hc2c2_c2c2_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] c_R  = 128'h5eed_5eed_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] c_R1 = 128'h0000_0000_0000_0000_0000_0000_0000_00a1;
  localparam logic [127:0] c_R2 = 128'h0000_0000_0000_0000_0000_0000_0000_00a2;

  // label memory model with one-cycle read latency
  logic [c_LW-1:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int wr_count = 0, rd_count = 0, ev_cycles = 0, both_high = 0;
  logic [c_AW-1:0] log_addr [0:63];
  logic [c_LW-1:0] log_data [0:63];
  always @(negedge clk) begin
    if (mem_wr_en) begin
      log_addr[wr_count[5:0]] = mem_addr;
      log_data[wr_count[5:0]] = mem_wr_data;
      wr_count = wr_count + 1;
    end
    if (mem_rd_en) rd_count = rd_count + 1;
    if (eval_valid) ev_cycles = ev_cycles + 1;
    if (mem_rd_en && mem_wr_en) both_high = both_high + 1;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_gate(input logic [1:0] t, input logic [23:0] i1, input logic [23:0] i2,
                           input logic [23:0] gid, input bit hold2);
    gate_type = t; gate_strobe = 1; tick; gate_strobe = 0; tick;
    input_id = i1; id_1_strobe = 1; tick; id_1_strobe = 0; tick;
    if (t != 2'd2) begin
      input_id = i2; id_2_strobe = 1; tick; id_2_strobe = 0; tick;
    end
    for (int k = 0; k < 3; k++) begin
      ctxt = (k == 0) ? c_C0 : (k == 1) ? c_C1 : c_C2;
      ctxt_idx = 2'(k + 1);
      ctxt_strobe = 1; tick; ctxt_strobe = 0; tick;
    end
    gate_id = gid; gate_id_strobe = 1; tick;
    if (hold2) tick;
    gate_id_strobe = 0; tick;
  endtask

  task automatic wait_wr(input string name, input int target);
    int n = 0;
    while (wr_count < target && n < 100) begin tick; n++; end
    check(name, 384'(wr_count >= target), 384'd1);
  endtask

  task automatic wait_ev(input string name);
    int n = 0;
    while (!eval_valid && n < 100) begin tick; n++; end
    check(name, 384'(eval_valid), 384'd1);
  endtask

  task automatic run_core(input string name, input logic [127:0] res);
    wait_ev(name);
    eval_ready = 1; tick; eval_ready = 0; tick;
    eval_done = 1; eval_result = res; tick; eval_done = 0; eval_result = '0;
  endtask

  int base, rbase, ebase;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[1] = c_L1; mem[2] = c_L2; mem[5] = c_L5; mem[6] = c_L6; mem[7] = c_L7;

    // reset state
    tick; tick; tick;
    check("rst_busy", 384'(busy), 0);
    check("rst_overflow", 384'(overflow), 0);
    check("rst_bad_job", 384'(bad_job), 0);
    check("rst_gates_done", 384'(gates_done), 0);
    check("rst_rd_en", 384'(mem_rd_en), 0);
    check("rst_wr_en", 384'(mem_wr_en), 0);
    check("rst_eval_valid", 384'(eval_valid), 0);
    rst = 0; tick;

    // XOR, gate_id_strobe held two cycles (must commit once)
    base = wr_count; rbase = rd_count;
    send_gate(2'd1, 24'd5, 24'd6, 24'd9, 1'b1);
    wait_wr("xor_wait", base + 1);
    tick; tick; tick; tick; tick; tick;
    check("xor_count", 384'(wr_count - base), 1);
    check("xor_addr", 384'(log_addr[base[5:0]]), 9);
    check("xor_data", 384'(log_data[base[5:0]]), 384'(c_L5 ^ c_L6));
    check("xor_reads", 384'(rd_count - rbase), 2);
    check("xor_gates_done", 384'(gates_done), 1);
    check("xor_busy", 384'(busy), 0);
    check("xor_overflow", 384'(overflow), 0);

    // AND with stalled core
    base = wr_count;
    send_gate(2'd0, 24'd1, 24'd2, 24'd3, 1'b0);
    wait_ev("and_ev");
    check("and_a", 384'(eval_a), 384'(c_L1));
    check("and_b", 384'(eval_b), 384'(c_L2));
    check("and_ctxt", eval_ctxt, {c_C2, c_C1, c_C0});
    tick; tick; tick; tick;
    check("and_held", 384'(eval_valid), 1);
    check("and_a_stable", 384'(eval_a), 384'(c_L1));
    check("and_b_stable", 384'(eval_b), 384'(c_L2));
    eval_ready = 1; tick; eval_ready = 0;
    check("and_valid_drop", 384'(eval_valid), 0);
    tick; tick;
    check("and_no_early_wr", 384'(wr_count - base), 0);
    eval_done = 1; eval_result = c_R; tick; eval_done = 0; eval_result = '0;
    wait_wr("and_wait", base + 1);
    check("and_addr", 384'(log_addr[base[5:0]]), 3);
    check("and_data", 384'(log_data[base[5:0]]), 384'(c_R));
    check("and_gates_done", 384'(gates_done), 2);

    // BUF
    base = wr_count; rbase = rd_count; ebase = ev_cycles;
    send_gate(2'd2, 24'd7, 24'd0, 24'd8, 1'b0);
    wait_wr("buf_wait", base + 1);
    tick; tick; tick;
    check("buf_count", 384'(wr_count - base), 1);
    check("buf_addr", 384'(log_addr[base[5:0]]), 8);
    check("buf_data", 384'(log_data[base[5:0]]), 384'(c_L7));
    check("buf_reads", 384'(rd_count - rbase), 1);
    check("buf_no_eval", 384'(ev_cycles - ebase), 0);
    check("buf_gates_done", 384'(gates_done), 3);

    // overflow: three AND jobs while the core stalls
    base = wr_count;
    send_gate(2'd0, 24'd5, 24'd6, 24'd20, 1'b0);
    send_gate(2'd0, 24'd1, 24'd2, 24'd21, 1'b0);
    send_gate(2'd0, 24'd6, 24'd7, 24'd22, 1'b0);
    check("ovf_flag", 384'(overflow), 1);
    check("ovf_busy", 384'(busy), 1);
    run_core("ovf_core1", c_R1);
    wait_wr("ovf_wait1", base + 1);
    run_core("ovf_core2", c_R2);
    wait_wr("ovf_wait2", base + 2);
    for (int i = 0; i < 30; i++) tick;
    check("ovf_count", 384'(wr_count - base), 2);
    check("ovf_addr0", 384'(log_addr[base[5:0]]), 20);
    check("ovf_data0", 384'(log_data[base[5:0]]), 384'(c_R1));
    check("ovf_addr1", 384'(log_addr[6'(base + 1)]), 21);
    check("ovf_data1", 384'(log_data[6'(base + 1)]), 384'(c_R2));
    check("ovf_sticky", 384'(overflow), 1);
    check("ovf_idle", 384'(busy), 0);

    // bad_job: illegal type, then out-of-range id
    rst = 1; tick; rst = 0; tick;
    base = wr_count;
    send_gate(2'd3, 24'd5, 24'd6, 24'd30, 1'b0);
    send_gate(2'd1, 24'h000400, 24'd6, 24'd31, 1'b0);
    for (int i = 0; i < 15; i++) tick;
    check("bad_flag", 384'(bad_job), 1);
    check("bad_no_write", 384'(wr_count - base), 0);
    check("bad_busy", 384'(busy), 0);
    check("bad_overflow", 384'(overflow), 0);
    check("bad_gates_done", 384'(gates_done), 0);

    // reset during EVAL_WAIT
    base = wr_count;
    send_gate(2'd0, 24'd1, 24'd2, 24'd40, 1'b0);
    wait_ev("rstj_ev");
    eval_ready = 1; tick; eval_ready = 0; tick;
    rst = 1; tick;
    check("rstj_busy", 384'(busy), 0);
    check("rstj_eval_valid", 384'(eval_valid), 0);
    check("rstj_bad_job", 384'(bad_job), 0);
    check("rstj_eval_a", 384'(eval_a), 0);
    check("rstj_wr_en", 384'(mem_wr_en), 0);
    rst = 0; tick;
    eval_done = 1; eval_result = c_R; tick; eval_done = 0;
    for (int i = 0; i < 10; i++) tick;
    check("rstj_no_write", 384'(wr_count - base), 0);
    check("rstj_gates_done", 384'(gates_done), 0);
    check("rd_wr_exclusive", 384'(both_high), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
